// File: rtl/segmented_carry_adder.sv
// Pipelined WIDTH-bit adder/subtractor built from SEG-bit carry segments.
// One segment per stage; the inter-segment carry is registered. A single global stall covers the whole pipe.
module segmented_carry_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = WIDTH / SEG;

  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x, input logic [SEG-1:0] y,
                                           input logic c);
    seg_add = {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, c};
  endfunction

  logic advance_s;

  assign advance_s = !out_valid || out_ready;
  assign in_ready  = advance_s;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam int LO  = k * SEG;
    localparam int OPW = WIDTH - LO;

    logic [OPW-1:0]    op_a_s;
    logic [OPW-1:0]    op_b_s;
    logic              c_in_s;
    logic              v_in_s;
    logic [SEG:0]      seg_s;
    logic [LO+SEG-1:0] res_nxt_s;
    logic [LO+SEG-1:0] res_r;
    logic              carry_r;
    logic              valid_r;

    assign seg_s = seg_add(op_a_s[SEG-1:0], op_b_s[SEG-1:0], c_in_s);

    if (k == 0) begin : g_head
      assign op_a_s    = a;
      assign op_b_s    = sub ? ~b : b;
      assign c_in_s    = sub ? 1'b1 : cin;
      assign v_in_s    = in_valid;
      assign res_nxt_s = seg_s[SEG-1:0];
    end else begin : g_body
      // Operands arrive from the previous stage's skew registers, already shifted down.
      assign op_a_s    = g_stage[k-1].g_skew.a_skew_r;
      assign op_b_s    = g_stage[k-1].g_skew.b_skew_r;
      assign c_in_s    = g_stage[k-1].carry_r;
      assign v_in_s    = g_stage[k-1].valid_r;
      assign res_nxt_s = {seg_s[SEG-1:0], g_stage[k-1].res_r};
    end

    // Stage result, carry and valid; data only loads on a real beat so retired results stay held.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        res_r   <= {(LO+SEG){1'b0}};
        carry_r <= 1'b0;
        valid_r <= 1'b0;
      end else if (advance_s) begin
        valid_r <= v_in_s;
        if (v_in_s) begin
          res_r   <= res_nxt_s;
          carry_r <= seg_s[SEG];
        end
      end
    end

    if (k < NSEG - 1) begin : g_skew
      logic [OPW-SEG-1:0] a_skew_r;
      logic [OPW-SEG-1:0] b_skew_r;

      // Carry the not-yet-added operand bits forward to their stage.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          a_skew_r <= {(OPW-SEG){1'b0}};
          b_skew_r <= {(OPW-SEG){1'b0}};
        end else if (advance_s && v_in_s) begin
          a_skew_r <= op_a_s[OPW-1:SEG];
          b_skew_r <= op_b_s[OPW-1:SEG];
        end
      end
    end else begin : g_msb
      logic ovf_r;

      // Carry into the MSB is recovered as a^b^s of that bit, then XORed with carry out.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ovf_r <= 1'b0;
        end else if (advance_s && v_in_s) begin
          ovf_r <= op_a_s[OPW-1] ^ op_b_s[OPW-1] ^ seg_s[SEG-1] ^ seg_s[SEG];
        end
      end
    end
  end

  assign out_valid = g_stage[NSEG-1].valid_r;
  assign sum       = g_stage[NSEG-1].res_r;
  assign cout      = g_stage[NSEG-1].carry_r;
  assign ovf       = g_stage[NSEG-1].g_msb.ovf_r;

endmodule
